// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int MEM_DEPTH_DEF  = 256;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Port id of a one-hot winner vector (bit 1 set means port 1).
  function automatic logic winner_id(input logic [1:0] winner);
    return winner[1];
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester and memory-side bus of the data memory arbiter.
interface data_memory_arbiter_if #(
  parameter int DATA_WIDTH = dmem_pkg::DATA_WIDTH_DEF
);
  logic                  req0, req1, we0, we1;
  logic [DATA_WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic                  gnt0, gnt1, done0, done1, err, busy;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] mem_address, mem_wdata, mem_rdata;
  logic                  mem_enable_read, mem_enable_write;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, err, busy, rdata,
           mem_address, mem_wdata, mem_enable_read, mem_enable_write
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, err, busy, rdata,
           mem_address, mem_wdata, mem_enable_read, mem_enable_write
  );
endinterface

// File: rtl/data_memory_arbiter_picker.sv
// Tie-break between the two requesters; a tie goes to the port that did not win last.
module dmem_arb_picker
  import dmem_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_winner,
  output logic [1:0] winner
);

  // One-hot winner selection
  always_comb begin
    winner = 2'b00;
    if (req0 && req1) begin
      if (last_winner == PORT0) begin
        winner = 2'b10;
      end else begin
        winner = 2'b01;
      end
    end else if (req0) begin
      winner = 2'b01;
    end else if (req1) begin
      winner = 2'b10;
    end else begin
      winner = 2'b00;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port data memory arbiter: IDLE -> ACCESS -> RESP, one access every three cycles.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to port 0.
module data_memory_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  data_memory_arbiter_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEM_DEPTH);

  state_t                state_r, state_nxt_s;
  logic                  id_r, we_r;
  logic [DATA_WIDTH-1:0] addr_r, wdata_r, rdata_r;
  logic                  gnt0_r, gnt1_r, done0_r, done1_r, err_r;
  logic                  oor_s, mem_rd_s, mem_wr_s, last_winner_s;
  logic [1:0]            winner_s;

  assign oor_s = (addr_r >= DEPTH_W);

  dmem_arb_picker u_picker (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_winner (last_winner_s),
    .winner      (winner_s)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_winner_r;

  // Remember the most recent grant so the next tie goes the other way
  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner_r <= PORT1;
    end else if (state_r == ST_IDLE && winner_s != 2'b00) begin
      last_winner_r <= winner_id(winner_s);
    end else begin
      last_winner_r <= last_winner_r;
    end
  end

  assign last_winner_s = last_winner_r;
`else
  assign last_winner_s = PORT1;
`endif

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Memory enables: only in ACCESS, only for legal addresses, never during reset
  always_comb begin
    mem_rd_s = 1'b0;
    mem_wr_s = 1'b0;
    if (!reset && state_r == ST_ACCESS && !oor_s) begin
      mem_rd_s = !we_r;
      mem_wr_s = we_r;
    end else begin
      mem_rd_s = 1'b0;
      mem_wr_s = 1'b0;
    end
  end

  // State register, request latch and registered response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      id_r    <= PORT0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (winner_s != 2'b00) begin
            id_r   <= winner_id(winner_s);
            gnt0_r <= winner_s[0];
            gnt1_r <= winner_s[1];
            if (winner_s[1]) begin
              we_r    <= bus.we1;
              addr_r  <= bus.addr1;
              wdata_r <= bus.wdata1;
            end else begin
              we_r    <= bus.we0;
              addr_r  <= bus.addr0;
              wdata_r <= bus.wdata0;
            end
          end else begin
            id_r <= id_r;
          end
        end
        ST_ACCESS: begin
          done0_r <= (id_r == PORT0);
          done1_r <= (id_r == PORT1);
          err_r   <= oor_s;
          if (oor_s) begin
            rdata_r <= '0;
          end else if (!we_r) begin
            rdata_r <= bus.mem_rdata;
          end else begin
            rdata_r <= rdata_r;
          end
        end
        default: begin
          id_r <= id_r;
        end
      endcase
    end
  end

  assign bus.gnt0             = gnt0_r;
  assign bus.gnt1             = gnt1_r;
  assign bus.done0            = done0_r;
  assign bus.done1            = done1_r;
  assign bus.err              = err_r;
  assign bus.rdata            = rdata_r;
  assign bus.busy             = (state_r != ST_IDLE);
  assign bus.mem_address      = addr_r;
  assign bus.mem_wdata        = wdata_r;
  assign bus.mem_enable_read  = mem_rd_s;
  assign bus.mem_enable_write = mem_wr_s;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter with a behavioural 256-word memory.
module tb_data_memory_arbiter;

  logic clock = 1'b0;
  logic reset;

  data_memory_arbiter_if #(.DATA_WIDTH(32)) bus ();

  data_memory_arbiter #(.DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] mem_model [0:255];
  logic        preload_en;
  logic [7:0]  preload_addr;
  logic [31:0] preload_data;
  int          write_count = 0;
  int          check_count = 0;
  int          error_count = 0;
  int          wc_start;
  logic [7:0]  ctrl_s;

  assign bus.mem_rdata = (bus.mem_address < 32'd256) ? mem_model[bus.mem_address[7:0]] : 32'd0;
  assign ctrl_s = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy,
                   bus.mem_enable_read, bus.mem_enable_write};

  // Memory model: asynchronous read, write on the rising edge
  always @(posedge clock) begin
    if (preload_en) begin
      mem_model[preload_addr] <= preload_data;
    end else if (bus.mem_enable_write) begin
      mem_model[bus.mem_address[7:0]] <= bus.mem_wdata;
      write_count <= write_count + 1;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
  endtask

  int exp_winner [4];

  initial begin
    reset = 1'b1;
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    preload_en = 1'b1; preload_addr = 8'd0; preload_data = 32'd10;
    step(1);
    preload_addr = 8'd1; preload_data = 32'd5;
    step(1);
    preload_en = 1'b0;
    step(1);
    check_value("reset_ctrl", {24'd0, ctrl_s}, 32'd0);
    check_value("reset_rdata", bus.rdata, 32'd0);
    reset = 1'b0;

    // Port 0 reads mem[0]
    drive0(1'b1, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("rd0_ctrl_access", {24'd0, ctrl_s}, 32'b1000_0110);
    check_value("rd0_mem_address", bus.mem_address, 32'd0);
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("rd0_ctrl_resp", {24'd0, ctrl_s}, 32'b0010_0100);
    check_value("rd0_rdata", bus.rdata, 32'd10);
    step(1);
    check_value("rd0_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Port 1 writes addr 5, then port 0 reads it back
    wc_start = write_count;
    drive1(1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    step(1);
    check_value("wr1_ctrl_access", {24'd0, ctrl_s}, 32'b0100_0101);
    check_value("wr1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("wr1_ctrl_resp", {24'd0, ctrl_s}, 32'b0001_0100);
    step(1);
    drive0(1'b1, 1'b0, 32'd5, 32'd0);
    step(1);
    check_value("rd5_gnt0", {31'd0, bus.gnt0}, 32'd1);
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("rd5_done0", {31'd0, bus.done0}, 32'd1);
    check_value("rd5_rdata", bus.rdata, 32'hDEADBEEF);
    step(1);
    check_value("wr1_write_pulses", 32'(write_count - wc_start), 32'd1);

    // Out-of-range read
    drive0(1'b1, 1'b0, 32'd300, 32'd0);
    step(1);
    check_value("oor_ctrl_access", {24'd0, ctrl_s}, 32'b1000_0100);
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("oor_ctrl_resp", {24'd0, ctrl_s}, 32'b0010_1100);
    check_value("oor_rdata", bus.rdata, 32'd0);
    step(1);

    // req1 raised during port 0's ACCESS waits for IDLE
    drive0(1'b1, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("late_gnt0", {31'd0, bus.gnt0}, 32'd1);
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    drive1(1'b1, 1'b0, 32'd5, 32'd0);
    step(1);
    check_value("late_resp_gnt1", {30'd0, bus.done0, bus.gnt1}, 32'b10);
    step(1);
    check_value("late_idle_gnt1", {30'd0, bus.busy, bus.gnt1}, 32'b00);
    step(1);
    check_value("late_gnt1", {31'd0, bus.gnt1}, 32'd1);
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("late_done1", {31'd0, bus.done1}, 32'd1);
    check_value("late_rdata", bus.rdata, 32'hDEADBEEF);
    step(1);

    // Reset during the ACCESS of a write to addr 1
    wc_start = write_count;
    drive1(1'b1, 1'b1, 32'd1, 32'h0000_0077);
    step(1);
    check_value("rstw_mem_write", {31'd0, bus.mem_enable_write}, 32'd1);
    reset = 1'b1;
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check_value("rstw_write_forced", {31'd0, bus.mem_enable_write}, 32'd0);
    step(1);
    check_value("rstw_ctrl", {24'd0, ctrl_s}, 32'd0);
    check_value("rstw_rdata", bus.rdata, 32'd0);
    check_value("rstw_mem_bus", bus.mem_address | bus.mem_wdata, 32'd0);
    step(1);
    check_value("rstw_no_done", {24'd0, ctrl_s}, 32'd0);
    reset = 1'b0;
    check_value("rstw_no_write", 32'(write_count - wc_start), 32'd0);
    drive0(1'b1, 1'b0, 32'd1, 32'd0);
    step(1);
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
    check_value("rstw_done0", {31'd0, bus.done0}, 32'd1);
    check_value("rstw_read_back", bus.rdata, 32'd5);
    step(1);

    // Simultaneous requests held for four transactions from a fresh reset
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_winner = '{0, 1, 0, 1};
`else
    exp_winner = '{0, 0, 0, 0};
`endif
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    drive0(1'b1, 1'b0, 32'd0, 32'd0);
    drive1(1'b1, 1'b0, 32'd5, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_value($sformatf("tie%0d_gnt", i), {30'd0, bus.gnt1, bus.gnt0},
                  (exp_winner[i] == 1) ? 32'b10 : 32'b01);
      step(1);
      check_value($sformatf("tie%0d_done", i), {30'd0, bus.done1, bus.done0},
                  (exp_winner[i] == 1) ? 32'b10 : 32'b01);
      check_value($sformatf("tie%0d_rdata", i), bus.rdata,
                  (exp_winner[i] == 1) ? 32'hDEADBEEF : 32'd10);
      step(1);
    end
    drive0(1'b0, 1'b0, 32'd0, 32'd0);
    drive1(1'b0, 1'b0, 32'd0, 32'd0);
    step(2);
    check_value("final_idle", {24'd0, ctrl_s}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
